// File: rtl/wb_hub_if.sv
// Bundle of CPU-side request signals and Wishbone-side slave signals for wb_hub.
// The slave modport is the hub's view; the master modport is the surrounding CPU/slave fabric.
interface wb_hub_if #(
  parameter int NSLV = 4,
  parameter int AW   = 8,
  parameter int DW   = 8
);
  logic                 cs;
  logic                 we;
  logic [AW-1:0]        addr;
  logic [DW-1:0]        din;
  logic [DW-1:0]        dout;
  logic                 rdy;
  logic                 err;
  logic [NSLV-1:0]      wb_stbo;
  logic                 wb_rwo;
  logic [AW-1:0]        wb_adro;
  logic [DW-1:0]        wb_dato;
  logic [NSLV-1:0]      wb_acki;
  logic [NSLV*DW-1:0]   wb_dati;

  modport slave (
    input  cs, we, addr, din,
    output dout, rdy, err,
    output wb_stbo, wb_rwo, wb_adro, wb_dato,
    input  wb_acki, wb_dati
  );

  modport master (
    output cs, we, addr, din,
    input  dout, rdy, err,
    input  wb_stbo, wb_rwo, wb_adro, wb_dato,
    output wb_acki, wb_dati
  );
endinterface

// File: rtl/wb_hub.sv
// Address-decoded Wishbone hub: one-hot strobes, registered read-data mux, ack timeout.
// state  | meaning
// IDLE   | waiting for cs; latches request and decodes slave index
// STROBE | strobe to selected slave, counting cycles until ack or timeout
// DONE   | rdy high with result; held until cs is sampled low
module wb_hub #(
  parameter int            NSLV     = 4,
  parameter int            AW       = 8,
  parameter int            DW       = 8,
  parameter int            TIMEOUT  = 15,
  parameter logic [DW-1:0] ERR_DATA = {DW{1'b1}}
) (
  input logic     clk,
  input logic     rst,
  wb_hub_if.slave bus
);

  localparam int            CW       = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam bit            TMO_EN   = (TIMEOUT != 0);
  localparam logic [CW-1:0] TMO_LAST = TMO_EN ? CW'(TIMEOUT - 1) : '0;
  localparam logic [4:0]    NSLV_W   = 5'(NSLV);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STROBE,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      idx_q, idx_d;
  logic [AW-1:0]   adr_q, adr_d;
  logic [DW-1:0]   dat_q, dat_d;
  logic            rw_q, rw_d;
  logic [NSLV-1:0] stb_q, stb_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   dout_q, dout_d;
  logic            rdy_q, rdy_d;
  logic            err_q, err_d;

  logic [3:0]      req_idx;
  logic            req_hit;
  logic            ack_sel;
  logic [DW-1:0]   rdat_sel;
  logic            tmo;
  logic [CW-1:0]   cnt_inc;

  assign req_idx = bus.addr[AW-1:AW-4];
  assign req_hit = ({1'b0, req_idx} < NSLV_W);

  // Only the latched slave's ack and data are visible; other acks are ignored.
  always_comb begin
    ack_sel  = 1'b0;
    rdat_sel = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (idx_q == 4'(i)) begin
        ack_sel  = bus.wb_acki[i];
        rdat_sel = bus.wb_dati[i*DW +: DW];
      end
    end
  end

  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CW'(1);
  assign tmo     = TMO_EN && (cnt_q == TMO_LAST);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    rw_d    = rw_q;
    stb_d   = stb_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    rdy_d   = rdy_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        if (bus.cs) begin
          adr_d = bus.addr;
          rw_d  = bus.we;
          dat_d = bus.din;
          idx_d = req_idx;
          cnt_d = '0;
          if (req_hit) begin
            for (int i = 0; i < NSLV; i++) begin
              stb_d[i] = (req_idx == 4'(i));
            end
            state_d = S_STROBE;
          end else begin
            rdy_d   = 1'b1;
            err_d   = 1'b1;
            dout_d  = ERR_DATA;
            state_d = S_DONE;
          end
        end
      end

      S_STROBE: begin
        // Ack is checked first so an ack on the timeout cycle still completes cleanly.
        if (ack_sel) begin
          stb_d   = '0;
          dout_d  = rw_q ? '0 : rdat_sel;
          err_d   = 1'b0;
          rdy_d   = 1'b1;
          state_d = S_DONE;
        end else if (tmo) begin
          stb_d   = '0;
          cnt_d   = cnt_inc;
          dout_d  = ERR_DATA;
          err_d   = 1'b1;
          rdy_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_DONE: begin
        if (!bus.cs) begin
          rdy_d   = 1'b0;
          err_d   = 1'b0;
          dout_d  = '0;
          state_d = S_IDLE;
        end
      end

      default: begin
        stb_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      rw_q    <= 1'b0;
      stb_q   <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      rw_q    <= rw_d;
      stb_q   <= stb_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
    end
  end

  assign bus.wb_stbo = stb_q;
  assign bus.wb_rwo  = rw_q;
  assign bus.wb_adro = adr_q;
  assign bus.wb_dato = dat_q;
  assign bus.dout    = dout_q;
  assign bus.rdy     = rdy_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_wb_hub.sv
// Directed bench for wb_hub: stimulus pushes expected completions, a monitor checks them on rdy.
module tb_wb_hub;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  wb_hub_if #(.NSLV(4), .AW(8), .DW(8)) bus();

  wb_hub #(
    .NSLV(4), .AW(8), .DW(8), .TIMEOUT(15), .ERR_DATA(8'hFF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [7:0] dout;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  logic rdy_prev = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Scoreboard monitor: one expected entry per rising rdy.
  always @(negedge clk) begin
    if (rst && bus.rdy && !rdy_prev) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rdy", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_dout", 32'(bus.dout), 32'(mon_e.dout));
        check("sb_err", 32'(bus.err), 32'(mon_e.err));
      end
    end
    rdy_prev <= bus.rdy;
  end

  task automatic txn(input string name, input bit w, input logic [7:0] a, input logic [7:0] d,
                     input int ack_at, input logic [3:0] other_ack, input logic [3:0] exp_stb,
                     input logic [7:0] exp_dout, input bit exp_err, input int exp_lat,
                     input int exp_cyc, input int drop_at);
    int c = 0;
    int stb_cyc = 0;
    int stb_bad = 0;
    bit done = 1'b0;
    exp_q.push_back({exp_dout, exp_err});
    bus.cs      = 1'b1;
    bus.we      = w;
    bus.addr    = a;
    bus.din     = d;
    bus.wb_acki = other_ack;
    while (!done && c < 40) begin
      @(negedge clk);
      c++;
      if (bus.rdy) begin
        done = 1'b1;
      end else begin
        if (bus.wb_stbo != 4'b0000) begin
          stb_cyc++;
          if (bus.wb_stbo !== exp_stb) stb_bad++;
          if (bus.wb_rwo !== w || bus.wb_adro !== a) stb_bad++;
          if (w && bus.wb_dato !== d) stb_bad++;
        end
        if (drop_at > 0 && c == drop_at) bus.cs = 1'b0;
        if (ack_at > 0 && c >= ack_at) bus.wb_acki = other_ack | exp_stb;
      end
    end
    bus.wb_acki = 4'b0000;
    check({name, "_done"}, 32'(done), 32'd1);
    if (!done) begin
      bus.cs = 1'b0;
      repeat (3) @(negedge clk);
      void'(exp_q.pop_back());
      return;
    end
    check({name, "_lat"}, 32'(c), 32'(exp_lat));
    check({name, "_stb_cycles"}, 32'(stb_cyc), 32'(exp_cyc));
    check({name, "_stb_value"}, 32'(stb_bad), 32'd0);
    if (drop_at > 0) begin
      @(negedge clk);
      check({name, "_rdy_pulse"}, 32'(bus.rdy), 32'd0);
    end else begin
      repeat (2) begin
        @(negedge clk);
        check({name, "_rdy_hold"}, {bus.rdy, bus.err, bus.dout}, {1'b1, exp_err, exp_dout});
      end
      bus.cs = 1'b0;
      @(negedge clk);
      check({name, "_release"}, {bus.rdy, bus.err, bus.dout}, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.cs      = 1'b0;
    bus.we      = 1'b0;
    bus.addr    = 8'h00;
    bus.din     = 8'h00;
    bus.wb_acki = 4'b0000;
    bus.wb_dati = {8'h44, 8'h33, 8'h22, 8'h11};

    @(negedge clk);
    check("reset_outputs",
          {bus.wb_stbo, bus.wb_rwo, bus.wb_adro, bus.wb_dato, bus.dout, bus.rdy, bus.err}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    bus.wb_dati = {8'h44, 8'h33, 8'h5C, 8'h11};
    txn("read", 1'b0, 8'h1A, 8'h00, 3, 4'b0000, 4'b0010, 8'h5C, 1'b0, 4, 3, 0);

    bus.wb_dati = {8'h44, 8'h33, 8'h22, 8'h11};
    txn("write", 1'b1, 8'h08, 8'hA5, 1, 4'b0000, 4'b0001, 8'h00, 1'b0, 2, 1, 0);

    txn("miss", 1'b0, 8'h70, 8'h00, 0, 4'b0000, 4'b0000, 8'hFF, 1'b1, 1, 0, 0);

    txn("timeout", 1'b0, 8'h35, 8'h00, 0, 4'b0000, 4'b1000, 8'hFF, 1'b1, 16, 15, 0);

    bus.wb_dati = {8'h3C, 8'h33, 8'h22, 8'h11};
    txn("ack_at_limit", 1'b0, 8'h35, 8'h00, 15, 4'b0000, 4'b1000, 8'h3C, 1'b0, 16, 15, 0);

    bus.wb_dati = {8'h44, 8'h9E, 8'h22, 8'h11};
    txn("wrong_ack", 1'b0, 8'h2C, 8'h00, 5, 4'b1000, 4'b0100, 8'h9E, 1'b0, 6, 5, 0);

    bus.wb_dati = {8'h44, 8'h33, 8'hC7, 8'h11};
    txn("cs_drop", 1'b0, 8'h1A, 8'h00, 4, 4'b0000, 4'b0010, 8'hC7, 1'b0, 5, 4, 2);

    // Reset in the middle of a strobe must clear outputs without waiting for a clock edge.
    bus.cs   = 1'b1;
    bus.we   = 1'b0;
    bus.addr = 8'h25;
    repeat (2) @(negedge clk);
    check("rst_pre_stb", 32'(bus.wb_stbo), 32'h4);
    #2 rst = 1'b0;
    #1;
    check("rst_async_outputs",
          {bus.wb_stbo, bus.wb_rwo, bus.wb_adro, bus.wb_dato, bus.dout, bus.rdy, bus.err}, 32'd0);
    bus.cs = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    bus.wb_dati = {8'h44, 8'h6B, 8'h22, 8'h11};
    txn("post_reset", 1'b0, 8'h25, 8'h00, 2, 4'b0000, 4'b0100, 8'h6B, 1'b0, 3, 2, 0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_hub.md
# wb_hub

Parametrised Wishbone-style hub between the CPU byte-register port and `NSLV` hard-IP slaves (SB_SPI/SB_I2C-class cores). It replaces OR-muxed data/ack with address-decoded per-slave strobes, a registered read-data mux and an ack timeout with error reporting. It sits between the CPU peripheral select and the IP-core instances.

## Interface
Parameters:
- `NSLV`, 4: number of slave channels (1..16); slave `i` owns `addr[AW-1:AW-4] == i`.
- `AW`, 8: address width (≥5).
- `DW`, 8: data width.
- `TIMEOUT`, 15: ack wait limit in cycles; 0 disables the timeout.
- `ERR_DATA`, all-ones of `DW`: `dout` value returned on error.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `cs`  in  1  CPU request; held high until `rdy`.
- `we`  in  1  1 = write, 0 = read.
- `addr`  in  AW  register address.
- `din`  in  DW  write data.
- `dout`  out  DW  read data, valid while `rdy` = 1.
- `rdy`  out  1  transaction complete.
- `err`  out  1  completion with decode miss or timeout; valid while `rdy` = 1.
- `wb_stbo`  out  NSLV  one-hot slave strobe.
- `wb_rwo`  out  1  1 = write.
- `wb_adro`  out  AW  bus address.
- `wb_dato`  out  DW  bus write data.
- `wb_acki`  in  NSLV  per-slave ack.
- `wb_dati`  in  NSLV*DW  per-slave read data; slave `i` at bits `[i*DW +: DW]`.

## Operation
- FSM states: IDLE, STROBE, DONE.
- IDLE: when `cs` = 1, latch `addr`, `we` and `din`, and compute `idx = addr[AW-1:AW-4]`.
  - If `idx < NSLV`: go to STROBE.
  - Otherwise (decode miss): go to DONE with `err` = 1, `dout` = `ERR_DATA`. No strobe is issued.
- STROBE:
  - `wb_stbo[idx]` = 1, all other strobe bits 0.
  - `wb_adro`, `wb_rwo` and `wb_dato` hold the latched values.
  - The wait counter increments each cycle.
  - Only `wb_acki[idx]` is observed; acks from other slaves are ignored.
- Ack sampled in STROBE: capture `wb_dati[idx*DW +: DW]` into `dout` (reads only; writes leave `dout` = 0), set `err` = 0, go to DONE.
- Timeout: when `TIMEOUT` ≠ 0 and the counter reaches `TIMEOUT` with no ack, go to DONE with `err` = 1, `dout` = `ERR_DATA`.
- Ack and timeout in the same cycle: the ack wins.
- DONE: `rdy` = 1 and all strobes 0. Stay while `cs` = 1; when `cs` is sampled 0, go to IDLE and clear `rdy`, `err` and `dout`.
- `cs` dropped before completion: the transaction still completes. DONE then lasts exactly one cycle, giving a one-cycle `rdy` pulse.
- Wait counter width is `$clog2(TIMEOUT+1)`, minimum 1. It clears on entry to STROBE and never wraps.

## Timing
- Reset (async, `rst` = 0): state IDLE; `wb_stbo`, `wb_rwo`, `wb_adro`, `wb_dato`, `dout`, `rdy`, `err` and the counter are all 0. Strobes drop immediately, not at the next edge.
- `cs` sampled at edge N → `wb_stbo` high after edge N.
- Ack first sampled at edge N+k (k ≥ 1) → strobe low and `rdy` high after edge N+k. Minimum CPU latency is 2 edges.
- Decode miss: `rdy`/`err` high after edge N (1 edge).
- Timeout: `rdy`/`err` high after edge N+`TIMEOUT`; the strobe is high for exactly `TIMEOUT` cycles.
- `cs` sampled low in DONE at edge M → `rdy` low after edge M.
- A new request is accepted no earlier than the edge after the return to IDLE; one idle cycle is guaranteed between strobes.
- All outputs are registered; no combinational path from `wb_acki`/`wb_dati` to `rdy`/`dout`.

## Test plan
- Read: NSLV=4, `addr`=0x1A, slave 1 acks with `wb_dati[15:8]`=0x5C three cycles after strobe → `wb_stbo`=4'b0010 for 3 cycles, `dout`=0x5C, `err`=0, `rdy` held until `cs` falls.
- Write: `addr`=0x08, `din`=0xA5, `we`=1, slave 0 acks after 1 cycle → `wb_rwo`=1, `wb_adro`=0x08, `wb_dato`=0xA5, `rdy` after 2 edges, `dout`=0.
- Decode miss: NSLV=4, `addr`=0x70 → no strobe ever asserted, `rdy`=1 and `err`=1 one edge after `cs`, `dout`=0xFF.
- Timeout and priority:
  - TIMEOUT=15 with no ack → strobe high exactly 15 cycles, then `err`=1, `dout`=0xFF.
  - Repeat with the ack arriving on cycle 15 → `err`=0 and captured data returned.
- Wrong ack: strobe to slave 2 while slave 3 acks continuously → slave 3's ack is ignored; completion occurs only on `wb_acki[2]`.
- Reset and `cs` drop:
  - `rst` low mid-strobe → `wb_stbo`=0 before the next edge, all outputs 0; `cs` is accepted normally after release.
  - `cs` dropped mid-strobe → a one-cycle `rdy` pulse at completion.
